// File: rtl/fabric_config_loader.sv
// Configuration-chain loader: host words are serialised into parallel tile
// shift chains, latched with one set pulse, and can be read back non-destructively.
module fabric_config_loader #(
  parameter int NUM_CHAINS = 4,
  parameter int CHAIN_LEN  = 1024,
  parameter int WORD_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [WORD_W-1:0]     cfg_word,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic [WORD_W-1:0]     rb_word,
  output logic                  rb_valid,
  input  logic                  rb_ready,
  output logic [NUM_CHAINS-1:0] shift_data,
  output logic                  shift_en,
  input  logic [NUM_CHAINS-1:0] chain_tail,
  output logic                  set_out,
  output logic                  busy,
  output logic                  done
);

  localparam int BPW = WORD_W / NUM_CHAINS;
  localparam int BW  = $clog2(CHAIN_LEN + 1);
  localparam int SW  = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [BW-1:0] LAST_BIT  = BW'(CHAIN_LEN - 1);
  localparam logic [BW-1:0] ALL_BITS  = BW'(CHAIN_LEN);
  localparam logic [SW-1:0] LAST_STEP = SW'(BPW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_SET,
    S_RB_SHIFT,
    S_RB_OUT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [SW-1:0]     step_cnt_q, step_cnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [WORD_W-1:0] rb_word_q, rb_word_d;
  logic              last_step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      step_cnt_q <= '0;
      word_q     <= '0;
      rb_word_q  <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      step_cnt_q <= step_cnt_d;
      word_q     <= word_d;
      rb_word_q  <= rb_word_d;
    end
  end

  // A word ends on its last slot or on the chain's last bit (partial word).
  assign last_step = (step_cnt_q == LAST_STEP) ||
                     (bit_cnt_q == LAST_BIT);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    step_cnt_d = step_cnt_q;
    word_d     = word_q;
    rb_word_d  = rb_word_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          bit_cnt_d  = '0;
          step_cnt_d = '0;
          state_d    = mode ? S_RB_SHIFT : S_LOAD;
        end
      end
      S_LOAD: begin
        if (cfg_valid) begin
          word_d  = cfg_word;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        bit_cnt_d  = bit_cnt_q + BW'(1);
        step_cnt_d = last_step ? '0 : step_cnt_q + SW'(1);
        if (last_step)
          state_d = (bit_cnt_q == LAST_BIT) ? S_SET : S_LOAD;
      end
      S_SET: state_d = S_DONE;
      S_RB_SHIFT: begin
        // First slot of a word starts from zero so partial words read 0.
        if (step_cnt_q == '0)
          rb_word_d = '0;
        for (int s = 0; s < BPW; s++)
          for (int c = 0; c < NUM_CHAINS; c++)
            if (step_cnt_q == SW'(s))
              rb_word_d[s*NUM_CHAINS+c] = chain_tail[c];
        bit_cnt_d  = bit_cnt_q + BW'(1);
        step_cnt_d = last_step ? '0 : step_cnt_q + SW'(1);
        if (last_step)
          state_d = S_RB_OUT;
      end
      S_RB_OUT: begin
        if (rb_ready)
          state_d = (bit_cnt_q == ALL_BITS) ? S_DONE : S_RB_SHIFT;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    shift_data = '0;
    if (state_q == S_SHIFT) begin
      for (int s = 0; s < BPW; s++)
        if (step_cnt_q == SW'(s))
          shift_data = word_q[s*NUM_CHAINS +: NUM_CHAINS];
    end else if (state_q == S_RB_SHIFT) begin
      shift_data = chain_tail;
    end
  end

  assign cfg_ready = (state_q == S_LOAD);
  assign shift_en  = (state_q == S_SHIFT) ||
                     (state_q == S_RB_SHIFT);
  assign rb_valid  = (state_q == S_RB_OUT);
  assign rb_word   = rb_word_q;
  assign set_out   = (state_q == S_SET);
  assign done      = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_fabric_config_loader.sv
// Directed bench for fabric_config_loader with a 2 x 10-bit chain model.
module tb_fabric_config_loader;

  localparam int NC = 2;
  localparam int CL = 10;
  localparam int WW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          rb_ready = 1'b0;
  logic [WW-1:0] cfg_word = '0;
  logic          cfg_ready, rb_valid, shift_en;
  logic          set_out, busy, done;
  logic [WW-1:0] rb_word;
  logic [NC-1:0] shift_data, chain_tail;
  logic [CL-1:0] chain0 = '0;
  logic [CL-1:0] chain1 = '0;

  int checks = 0;
  int errors = 0;
  int set_total = 0;

  logic [WW-1:0] words [3] = '{8'hA5, 8'h3C, 8'hFF};

  localparam logic [CL-1:0] EXP_C0 = 10'h31B;
  localparam logic [CL-1:0] EXP_C1 = 10'h0DB;

  always #5 clk = ~clk;

  fabric_config_loader #(
    .NUM_CHAINS(NC),
    .CHAIN_LEN (CL),
    .WORD_W    (WW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .cfg_word  (cfg_word),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .rb_word   (rb_word),
    .rb_valid  (rb_valid),
    .rb_ready  (rb_ready),
    .shift_data(shift_data),
    .shift_en  (shift_en),
    .chain_tail(chain_tail),
    .set_out   (set_out),
    .busy      (busy),
    .done      (done)
  );

  assign chain_tail = {chain1[CL-1], chain0[CL-1]};

  always @(posedge clk) begin
    if (shift_en) begin
      chain0 <= {chain0[CL-2:0], shift_data[0]};
      chain1 <= {chain1[CL-2:0], shift_data[1]};
    end
    if (set_out)
      set_total <= set_total + 1;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic viol;
    viol = ($countones({cfg_ready, rb_valid, shift_en}) > 1) ||
           (set_out && shift_en);
    check("exclusive", 32'(viol), 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input bit stall);
    int wi = 0, gap = 0, run = 0, ngrp = 0;
    int nshift = 0, nset = 0;
    int acc0 = -1, first_sh = -1, last_sh = -1;
    int set_cyc = -1, done_cyc = -1;
    int grp [4] = '{0, 0, 0, 0};
    start = 1; mode = 0;
    tick();
    start = 0;
    check("ld_busy", busy, 1);
    check("ld_ready", cfg_ready, 1);
    for (int cyc = 0; cyc < 100 && done_cyc < 0; cyc++) begin
      if (shift_en) begin
        run++; nshift++;
        if (first_sh < 0) first_sh = cyc;
        last_sh = cyc;
      end else if (run > 0) begin
        if (ngrp < 4) grp[ngrp] = run;
        ngrp++; run = 0;
      end
      if (set_out) begin nset++; set_cyc = cyc; end
      if (done) done_cyc = cyc;
      if (stall && wi == 1 && cfg_ready && gap < 5) begin
        cfg_valid = 0;
        gap++;
        check("stall_shift", shift_en, 0);
      end else begin
        cfg_valid = (wi < 3);
        cfg_word  = words[wi % 3];
      end
      if (cfg_valid && cfg_ready) begin
        if (wi == 0) acc0 = cyc;
        wi++;
      end
      tick();
    end
    cfg_valid = 0;
    check("ld_done_seen", 32'(done_cyc >= 0), 1);
    check("ld_done_cyc", done_cyc, stall ? 19 : 14);
    check("ld_nshift", nshift, 10);
    check("ld_ngrp", ngrp, 3);
    check("ld_grp0", grp[0], 4);
    check("ld_grp1", grp[1], 4);
    check("ld_grp2", grp[2], 2);
    check("ld_first", first_sh, acc0 + 1);
    check("ld_nset", nset, 1);
    check("ld_set_pos", set_cyc, last_sh + 1);
    check("ld_done_pos", done_cyc, set_cyc + 1);
    check("ld_idle", busy, 0);
    check("ld_chain0", chain0, EXP_C0);
    check("ld_chain1", chain1, EXP_C1);
  endtask

  task automatic do_readback();
    int ri = 0, hold = 0, done_cyc = -1;
    int set0;
    logic [WW-1:0] held = '0;
    logic [WW-1:0] exp [3] = '{8'hA5, 8'h3C, 8'h0F};
    set0 = set_total;
    start = 1; mode = 1;
    tick();
    start = 0; mode = 0;
    check("rb_busy", busy, 1);
    check("rb_first_shift", shift_en, 1);
    for (int cyc = 0; cyc < 100 && done_cyc < 0; cyc++) begin
      rb_ready = 0;
      if (done) done_cyc = cyc;
      if (rb_valid) begin
        if (ri == 1 && hold > 0)
          check("rb_stable", rb_word, held);
        if (ri == 1 && hold < 3) begin
          held = rb_word;
          hold++;
        end else begin
          if (ri < 3)
            check($sformatf("rb_word%0d", ri), rb_word, exp[ri]);
          rb_ready = 1;
          ri++;
        end
      end
      tick();
    end
    rb_ready = 0;
    check("rb_done_seen", 32'(done_cyc >= 0), 1);
    check("rb_nwords", ri, 3);
    check("rb_no_set", set_total, set0);
    check("rb_idle", busy, 0);
    check("rb_chain0", chain0, EXP_C0);
    check("rb_chain1", chain1, EXP_C1);
  endtask

  task automatic do_abort();
    int set0;
    set0 = set_total;
    start = 1; mode = 0;
    tick();
    start = 0;
    start = 1; mode = 1;
    tick();
    start = 0; mode = 0;
    check("bs_ready", cfg_ready, 1);
    check("bs_rb_valid", rb_valid, 0);
    check("bs_shift", shift_en, 0);
    cfg_valid = 1; cfg_word = 8'h5A;
    tick();
    cfg_valid = 0;
    check("ab_shift", shift_en, 1);
    check("ab_data0", shift_data, 2'b10);
    start = 1;
    tick();
    start = 0;
    check("ab_shift2", shift_en, 1);
    check("ab_data1", shift_data, 2'b10);
    #3 rst = 1;
    #1;
    check("ar_busy", busy, 0);
    check("ar_shift", shift_en, 0);
    check("ar_ready", cfg_ready, 0);
    check("ar_rb_valid", rb_valid, 0);
    check("ar_rb_word", rb_word, 0);
    check("ar_data", shift_data, 0);
    check("ar_set", set_out, 0);
    check("ar_done", done, 0);
    #2 rst = 0;
    repeat (5) tick();
    check("ar_idle", busy, 0);
    check("ar_no_set", set_total, set0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    start = 1; cfg_valid = 1; cfg_word = 8'hFF;
    repeat (3) tick();
    check("rst_ready", cfg_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_shift", shift_en, 0);
    check("rst_set", set_out, 0);
    check("rst_done", done, 0);
    check("rst_rb_valid", rb_valid, 0);
    check("rst_rb_word", rb_word, 0);
    check("rst_data", shift_data, 0);
    start = 0; cfg_valid = 0;
    #2 rst = 0;
    tick();
    check("idle_busy", busy, 0);
    do_load(1'b0);
    do_readback();
    do_abort();
    do_load(1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
